// File: rtl/iiitb_icg_bank.sv
// Multi-channel integrated clock-gating bank.
// Each channel has a gate latch, a gated data register, an idle counter for auto
// mode, and a saturating count of suppressed clock edges.
module iiitb_icg_bank #(
  parameter int unsigned CH       = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned IDLE_CYC = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH-1:0]         en_req,
  input  logic [CH*W-1:0]       d,
  input  logic                  cnt_clr,
  output logic [CH*W-1:0]       q,
  output logic [CH-1:0]         gclk,
  output logic [CH-1:0]         gate_on,
  output logic [CH*CNT_W-1:0]   gated_cnt
);

  localparam int unsigned IW = 8;
  localparam logic [IW-1:0]    IDLE_MAX = IW'(IDLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_SW   = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  logic [CH-1:0][1:0]       mode_r_q, mode_r_d;
  logic [CH-1:0]            req_r_q, req_r_d;
  logic [CH-1:0][W-1:0]     d_r_q, d_r_d;
  logic [CH-1:0][W-1:0]     q_q, q_d;
  logic [CH-1:0][IW-1:0]    idle_q, idle_d;
  logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CH-1:0]            act;
  logic [CH-1:0]            gate_en;
  logic [CH-1:0]            gate_q;

  // Gate request, idle tracking, data capture and suppressed-edge counting.
  always_comb begin
    mode_r_d = mode;
    req_r_d  = en_req;
    d_r_d    = d;
    q_d      = q_q;
    idle_d   = idle_q;
    cnt_d    = cnt_q;
    act      = '0;
    gate_en  = '0;
    for (int c = 0; c < CH; c++) begin
      act[c] = (d_r_q[c] != q_q[c]);

      case (mode_r_q[c])
        MODE_OFF: gate_en[c] = 1'b0;
        MODE_ON:  gate_en[c] = 1'b1;
        MODE_SW:  gate_en[c] = req_r_q[c];
        default:  gate_en[c] = act[c] | (idle_q[c] < IDLE_MAX);
      endcase
      gate_en[c] = gate_en[c] & rst_n;

      // Capturing only when the gate is open matches a register on gclk.
      if (gate_q[c]) begin
        q_d[c] = d_r_q[c];
      end

      // Outside auto mode park the counter at the limit so auto starts gated.
      if (mode_r_q[c] == MODE_AUTO) begin
        if (act[c]) begin
          idle_d[c] = '0;
        end else if (idle_q[c] < IDLE_MAX) begin
          idle_d[c] = idle_q[c] + IW'(1);
        end
      end else begin
        idle_d[c] = IDLE_MAX;
      end

      if (cnt_clr) begin
        cnt_d[c] = '0;
      end else if (!gate_q[c] && (cnt_q[c] != CNT_MAX)) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r_q <= '0;
      req_r_q  <= '0;
      d_r_q    <= '0;
      q_q      <= '0;
      idle_q   <= {CH{IDLE_MAX}};
      cnt_q    <= '0;
    end else begin
      mode_r_q <= mode_r_d;
      req_r_q  <= req_r_d;
      d_r_q    <= d_r_d;
      q_q      <= q_d;
      idle_q   <= idle_d;
      cnt_q    <= cnt_d;
    end
  end

  // Gate latch: transparent while clk is low so gclk pulses are never clipped.
  always_latch begin
    if (!clk) begin
      gate_q = gate_en;
    end
  end

  assign gclk      = {CH{clk}} & gate_q;
  assign gate_on   = gate_q;
  assign q         = q_q;
  assign gated_cnt = cnt_q;

endmodule

// File: tb/tb_iiitb_icg_bank.sv
// Testbench for iiitb_icg_bank: directed scenarios plus randomized traffic
// checked against a per-channel behavioural model and a gclk pulse monitor.
module tb_iiitb_icg_bank;

  localparam int unsigned CH       = 4;
  localparam int unsigned W        = 8;
  localparam int unsigned IDLE_CYC = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int          HALF     = 5;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2*CH-1:0]     mode;
  logic [CH-1:0]       en_req;
  logic [CH*W-1:0]     d;
  logic                cnt_clr;
  logic [CH*W-1:0]     q;
  logic [CH-1:0]       gclk;
  logic [CH-1:0]       gate_on;
  logic [CH*CNT_W-1:0] gated_cnt;

  always #HALF clk = ~clk;

  iiitb_icg_bank #(
    .CH(CH), .W(W), .IDLE_CYC(IDLE_CYC), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en_req(en_req), .d(d),
    .cnt_clr(cnt_clr), .q(q), .gclk(gclk), .gate_on(gate_on),
    .gated_cnt(gated_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Observed gclk pulses and pulse-width checking.
  int          obs_pulses[CH];
  time         rise_t[CH];
  logic [CH-1:0] gclk_prev = '0;
  logic [CH-1:0] seen_rise = '0;

  always @(gclk) begin
    for (int c = 0; c < CH; c++) begin
      if (gclk[c] && !gclk_prev[c]) begin
        obs_pulses[c]++;
        rise_t[c]    = $time;
        seen_rise[c] = 1'b1;
        check($sformatf("gclk_rise_on_clk[%0d]", c), 32'(clk), 32'd1);
      end else if (!gclk[c] && gclk_prev[c] && seen_rise[c]) begin
        check($sformatf("gclk_width[%0d]", c), 32'($time - rise_t[c]), 32'(HALF));
      end
    end
    gclk_prev = gclk;
  end

  // Behavioural reference: per-channel state after each edge.
  int m_q[CH], m_dr[CH], m_mode[CH], m_req[CH], m_idle[CH], m_cnt[CH];
  int m_gate[CH], m_pulses[CH];

  function automatic int want_gate(input int c);
    if (!rst_n) return 0;
    case (m_mode[c])
      0:       return 0;
      1:       return 1;
      2:       return m_req[c];
      default: return ((m_dr[c] != m_q[c]) || (m_idle[c] < int'(IDLE_CYC))) ? 1 : 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_q[c] = 0; m_dr[c] = 0; m_mode[c] = 0; m_req[c] = 0;
      m_idle[c] = int'(IDLE_CYC); m_cnt[c] = 0;
    end
  endtask

  // One clock edge: predict, wait, compare, advance the model.
  task automatic step();
    int act;
    for (int c = 0; c < CH; c++) m_gate[c] = want_gate(c);
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("gate_on[%0d]", c), 32'(gate_on[c]), 32'(m_gate[c]));
      if (m_gate[c] != 0) m_pulses[c]++;
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        act = (m_dr[c] != m_q[c]) ? 1 : 0;
        if (m_mode[c] == 3) begin
          if (act != 0) m_idle[c] = 0;
          else if (m_idle[c] < int'(IDLE_CYC)) m_idle[c] = m_idle[c] + 1;
        end else begin
          m_idle[c] = int'(IDLE_CYC);
        end
        if (m_gate[c] != 0) m_q[c] = m_dr[c];
        if (cnt_clr) m_cnt[c] = 0;
        else if (m_gate[c] == 0) m_cnt[c] = (m_cnt[c] >= CNT_MAX) ? CNT_MAX : m_cnt[c] + 1;
        m_dr[c]   = int'(d[c*W +: W]);
        m_req[c]  = int'(en_req[c]);
        m_mode[c] = int'(mode[2*c +: 2]);
      end
    end
    for (int c = 0; c < CH; c++) begin
      check($sformatf("q[%0d]", c), 32'(q[c*W +: W]), 32'(m_q[c]));
      check($sformatf("gated_cnt[%0d]", c), 32'(gated_cnt[c*CNT_W +: CNT_W]), 32'(m_cnt[c]));
    end
  endtask

  int          base[CH];
  logic [CH*W-1:0] q_snap;
  int          rot;

  task automatic snap_base();
    for (int c = 0; c < CH; c++) base[c] = obs_pulses[c];
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      obs_pulses[c] = 0; m_pulses[c] = 0; rise_t[c] = 0;
    end
    rst_n = 1'b0; mode = '0; en_req = '0; d = '0; cnt_clr = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_q", 32'(q), 32'd0);
    check("rst_gate_on", 32'(gate_on), 32'd0);
    check("rst_gated_cnt", 32'(gated_cnt), 32'd0);

    // Force on for 10 edges, then force off for 10 edges.
    rst_n = 1'b1;
    mode = {CH{2'b01}}; cnt_clr = 1'b1; d = 32'($urandom);
    step();
    cnt_clr = 1'b0;
    snap_base();
    repeat (10) step();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("on_pulses[%0d]", c), 32'(obs_pulses[c] - base[c]), 32'd10);
      check($sformatf("on_cnt[%0d]", c), 32'(gated_cnt[c*CNT_W +: CNT_W]), 32'd0);
    end
    mode = {CH{2'b00}};
    step();
    snap_base();
    q_snap = q;
    d = 32'($urandom);
    repeat (10) step();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("off_pulses[%0d]", c), 32'(obs_pulses[c] - base[c]), 32'd0);
      check($sformatf("off_cnt[%0d]", c), 32'(gated_cnt[c*CNT_W +: CNT_W]), 32'd10);
    end
    check("off_q_held", 32'(q), 32'(q_snap));

    // Software enable on channel 1.
    mode = 8'b00_00_10_00; d = 32'h0000_A500; en_req = '0;
    repeat (3) step();
    en_req = 4'b0010;
    step();
    snap_base();
    step();
    check("sw_first_pulse", 32'(obs_pulses[1] - base[1]), 32'd1);
    check("sw_q_a5", 32'(q[1*W +: W]), 32'hA5);
    en_req = '0;
    step();
    snap_base();
    repeat (3) step();
    check("sw_off_pulses", 32'(obs_pulses[1] - base[1]), 32'd0);
    check("sw_off_gate", 32'(gate_on[1]), 32'd0);

    // Auto mode on channel 2: one data step, then IDLE_CYC trailing pulses.
    mode = 8'b00_11_00_00; d = '0;
    repeat (8) step();
    check("auto_idle_gate", 32'(gate_on[2]), 32'd0);
    d = 32'h003C_0000;
    step();
    snap_base();
    step();
    check("auto_open_pulse", 32'(obs_pulses[2] - base[2]), 32'd1);
    check("auto_q_3c", 32'(q[2*W +: W]), 32'h3C);
    snap_base();
    repeat (6) step();
    check("auto_tail_pulses", 32'(obs_pulses[2] - base[2]), 32'(IDLE_CYC));
    check("auto_closed", 32'(gate_on[2]), 32'd0);

    // Counter saturation and clear on a gated edge.
    mode = '0;
    repeat (20) step();
    check("sat_cnt0", 32'(gated_cnt[0 +: CNT_W]), 32'(CNT_MAX));
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_cnt0", 32'(gated_cnt[0 +: CNT_W]), 32'd0);
    step();
    check("clr_then_inc", 32'(gated_cnt[0 +: CNT_W]), 32'd1);

    // Reset asserted during a clk-high phase while auto channels are active.
    mode = {CH{2'b11}};
    repeat (6) begin
      d = 32'($urandom);
      step();
    end
    rst_n = 1'b0;
    step();
    check("midrst_q", 32'(q), 32'd0);
    check("midrst_gate_on", 32'(gate_on), 32'd0);
    check("midrst_cnt", 32'(gated_cnt), 32'd0);
    rst_n = 1'b1;

    // Independent channels in mixed modes with random traffic.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        rot = int'($urandom_range(0, 3));
        for (int c = 0; c < CH; c++) mode[2*c +: 2] = 2'((c + rot) % 4);
      end
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 3) == 0) d[c*W +: W] = 8'($urandom);
      en_req  = 4'($urandom);
      cnt_clr = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    for (int c = 0; c < CH; c++)
      check($sformatf("pulses_total[%0d]", c), 32'(obs_pulses[c]), 32'(m_pulses[c]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iiitb_icg_bank.md
# iiitb_icg_bank

Parametrised multi-channel integrated clock-gating bank, the next generation of the single-channel `iiitb_icg`. It provides CH independent gated clocks, each with a W-bit data register clocked by its own gated clock. Each channel has four gating modes: force-off, force-on, software enable, and auto (activity/idle-timeout). Per-channel saturating counters record suppressed clock cycles. It sits in the user project area behind `user_proj_example`, driven from io_in/LA pins.

## Interface
- `CH`, default 4: number of channels.
- `W`, default 8: data width per channel.
- `IDLE_CYC`, default 4: auto mode keeps the gate open for this many idle cycles after the last activity; legal range 1..255.
- `CNT_W`, default 16: width of each gated-cycle counter.
- `clk` input 1: the single clock; all state is on its posedge, except the gate latch, which is transparent while `clk` is low.
- `rst_n` input 1: synchronous, active-low reset.
- `mode` input 2*CH: per channel (ch c at [2c+1:2c]). 00 = force off, 01 = force on, 10 = software enable, 11 = auto.
- `en_req` input CH: per-channel software enable; used in mode 10 only.
- `d` input CH*W: channel data in; ch c at [c*W +: W].
- `cnt_clr` input 1: synchronous clear of all gated-cycle counters.
- `q` output CH*W: channel data registers; ch c at [c*W +: W].
- `gclk` output CH: gated clocks, `gclk[c] = clk & gate_q[c]`.
- `gate_on` output CH: `gate_q` per channel, i.e. the latched gate state.
- `gated_cnt` output CH*CNT_W: per-channel count of suppressed cycles; ch c at [c*CNT_W +: CNT_W].

## Operation
Pipeline per channel c, on each posedge:
- `mode_r <= mode`, `req_r <= en_req`, `d_r <= d`.
- `q <= d_r` only on edges where `gate_q == 1`, i.e. on `gclk` rising edges.

Gate request (combinational) for channel c:
- `act = (d_r != q)`.
- Mode 00: gate_en = 0.
- Mode 01: gate_en = 1.
- Mode 10: gate_en = req_r.
- Mode 11: gate_en = act | (idle_cnt < IDLE_CYC).
- gate_en is forced to 0 while `rst_n` is low.

Gate latch:
- `gate_q` follows gate_en while `clk` is low and holds while `clk` is high.
- This keeps `gclk` glitch-free: every `gclk` pulse is a full `clk` high phase or absent.

Idle counter (8 bits) per channel:
- In mode 11: if `act`, idle_cnt <= 0; else if idle_cnt < IDLE_CYC, idle_cnt <= idle_cnt + 1; otherwise hold.
- In modes 00/01/10: idle_cnt <= IDLE_CYC, so entering auto with no activity starts gated.

Gated-cycle counter per channel:
- `cnt_clr` has priority: counter <= 0.
- Else, on each posedge with `gate_q == 0`, counter <= counter + 1, saturating at 2^CNT_W - 1 (no wrap).

Reset (rst_n low at a posedge):
- q = 0, d_r = 0, req_r = 0, mode_r = 00, idle_cnt = IDLE_CYC, gated_cnt = 0.
- gate_q goes to 0 at the next `clk`-low phase; gclk = 0, gate_on = 0.
- Reset mid-pulse never truncates a `gclk` high phase already in progress.

Simultaneous events:
- `cnt_clr` with a gated edge: the counter reads 0, not 1.
- Activity on the same edge that idle_cnt reaches IDLE_CYC: the gate stays open.

## Timing
- Mode / en_req change seen at edge E0 → gate_q changes in the low phase after E0.
- First gated or ungated edge is E1, so control latency is 1 cycle.
- Data latency with the gate open: d at E0 → d_r → q at E1, i.e. 2 edges from the input pin.
- Auto mode: a d change opens the gate within 1 cycle. After the last activity, the gate stays open for exactly IDLE_CYC further edges, then closes.
- `gated_cnt` updates on the same edge that is suppressed; readable the next cycle.

## Test plan
- Force modes: all channels 01 for 10 cycles → 10 gclk pulses per channel, gated_cnt = 0. Then all channels 00 for 10 cycles → no pulses, gated_cnt = 10, q unchanged.
- Software enable, ch1 mode 10, d[ch1] = 8'hA5: en_req[1] 0→1 at edge E0 → first gclk[1] pulse at E1, q[ch1] = 8'hA5 at E1. en_req[1] 1→0 → gclk[1] absent from the next edge.
- Auto mode, IDLE_CYC = 4: ch2 d steps 0→8'h3C once → gate opens, q = 8'h3C. gclk[2] gives exactly 4 further pulses after the activity cycle, then stops; gate_on[2] = 0.
- Counter saturation with CNT_W = 4, ch0 forced off for 20 cycles → gated_cnt[ch0] stays 4'hF. cnt_clr on a gated edge → reads 0 next cycle.
- Reset mid-operation: rst_n low for 1 edge during auto activity → q = 0, gate_on = 0, gated_cnt = 0. No gclk pulse shorter than one clk high phase; a glitch checker on gclk is required.
- Independence: four channels in four different modes simultaneously, with random d → each channel matches its own reference model; no cross-channel effect.
